inhibit_window_counter: RTL
===========================

INHIBIT_WINDOW_COUNTER -- requirements
Module: inhibit_window_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, number of independent x/y channels (>=1).
REQ-002 The block SHALL have parameter CNT_W, default 8, width of the accumulated count (>=1).
REQ-003 The block SHALL have parameter WINDOW, default 16, number of RUN-cycle samples accumulated per measurement (>=1).
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 The block SHALL have port start  input  1  begins a measurement window when sampled high in IDLE.
REQ-007 The block SHALL have port x  input  WIDTH  per-channel inhibit input.
REQ-008 The block SHALL have port y  input  WIDTH  per-channel data input.
REQ-009 The block SHALL have port s  output  WIDTH  registered per-channel result.
REQ-010 The block SHALL have port count  output  CNT_W  accumulated hit count of the current or last window.
REQ-011 The block SHALL have port busy  output  1  high while in RUN.
REQ-012 The block SHALL have port done  output  1  one-cycle pulse when a window completes.
REQ-013 The block SHALL have port sat  output  1  sticky flag; count clipped during the current or last window.

Function
REQ-014 Per-channel hit SHALL be h[i] = y[i] AND NOT x[i]; s SHALL be h registered every cycle, in every state, with latency 1.
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 IDLE with start=1 SHALL go to RUN, clear count and sat, and zero the window counter; this edge samples no hits.
REQ-017 IDLE with start=0 SHALL hold count and sat unchanged.
REQ-018 In RUN, each edge SHALL add popcount(h), widened to avoid overflow, to count, saturating at 2^CNT_W-1.
REQ-019 Any addition that clips in RUN SHALL set sat, which SHALL remain set until the next accepted start or reset.
REQ-020 The window counter SHALL increment each RUN edge; the edge adding the WINDOW-th sample SHALL move the FSM to DONE.
REQ-021 A window SHALL accumulate exactly WINDOW samples.
REQ-022 DONE SHALL last exactly one cycle with done=1, count and sat held; then the FSM SHALL go to IDLE.
REQ-023 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-024 start SHALL be ignored in RUN and DONE, with no restart and no queuing.
REQ-025 A start arriving in the IDLE cycle right after DONE SHALL be accepted normally.
REQ-026 WINDOW=1 SHALL give one RUN cycle followed by DONE.

Reset
REQ-027 rst_n low at a rising edge SHALL force s=0, count=0, sat=0, busy=0, done=0, FSM=IDLE and window counter=0, taking precedence over start.
REQ-028 Reset in RUN or DONE SHALL abort the window with no done pulse, and the accumulated count SHALL be discarded.
REQ-029 Reset SHALL have no asynchronous effect; outputs SHALL change only at clock edges.

Verification (WIDTH=4, CNT_W=8, WINDOW=16 unless stated)
REQ-030 Reset test: rst_n=0 for 2 edges with x=0, y=4'hF, start=1 -> s=0, count=0, busy=0, done=0, sat=0; after release with start=0 -> s=4'hF one edge later and the FSM stays in IDLE.
REQ-031 Logic test: x=4'b0101, y=4'b0011, then x=4'b1111, y=4'b1111 -> s=4'b0010, then 4'b0000, each one edge after its input.
REQ-032 Window test: start for 1 cycle, then x=0, y=4'b0011 held -> busy high for 16 cycles, done high for the single following cycle, count=32, sat=0; start pulsed mid-RUN changes nothing.
REQ-033 Saturation test (CNT_W=5): x=0, y=4'hF for the full window -> count=31, sat=1 at done.
REQ-034 Saturation clear test: a second start after REQ-033 -> count restarts from 0 and sat=0.
REQ-035 Abort test: rst_n=0 at RUN cycle 5 -> next edge count=0, busy=0, no done; a fresh start then yields a normal 16-sample window.

Source files
------------

// File: rtl/inhibit_window_counter.sv
// Inhibit-gated hit counter: per-channel hit = y & ~x, registered onto s every
// cycle; a start in IDLE opens a WINDOW-sample measurement that accumulates the
// popcount of hits into a saturating count, then pulses done for one cycle.
module inhibit_window_counter #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned WINDOW = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] s,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             sat
);

  localparam int unsigned PcW   = $clog2(WIDTH + 1);
  localparam int unsigned SumW  = ((CNT_W > PcW) ? CNT_W : PcW) + 1;
  localparam int unsigned WinW  = $clog2(WINDOW + 1);
  localparam logic [SumW-1:0]  CntMax  = SumW'({CNT_W{1'b1}});
  localparam logic [WinW-1:0]  WinLast = WinW'(WINDOW - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;
  logic [WinW-1:0]  win_q, win_d;
  logic [WIDTH-1:0] s_q;

  logic [WIDTH-1:0] hit;
  logic [PcW-1:0]   pop;
  logic [SumW-1:0]  sum;

  // Per-channel hits and their population count.
  always_comb begin
    hit = y & ~x;
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + PcW'(hit[i]);
    end
  end

  // Widened sum so the saturation compare cannot itself overflow.
  assign sum = SumW'(count_q) + SumW'(pop);

  // Next-state and datapath update for the measurement FSM.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sat_d   = sat_q;
    win_d   = win_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          count_d = '0;
          sat_d   = 1'b0;
          win_d   = '0;
        end
      end
      StRun: begin
        if (sum > CntMax) begin
          count_d = CntMax[CNT_W-1:0];
          sat_d   = 1'b1;
        end else begin
          count_d = sum[CNT_W-1:0];
        end
        win_d = win_q + 1'b1;
        if (win_q == WinLast) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
      sat_q   <= 1'b0;
      win_q   <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sat_q   <= sat_d;
      win_q   <= win_d;
      s_q     <= hit;
    end
  end

  assign s     = s_q;
  assign count = count_q;
  assign sat   = sat_q;
  assign busy  = (state_q == StRun);
  assign done  = (state_q == StDone);

endmodule
